// File: rtl/mem_arbiter.sv
// Purpose: shares one RAM port among NCPU dcache and NCPU icache ports, locking the grant for a block transfer.
// Latency: 1 IDLE cycle of arbitration, then RAM strobes driven combinationally from the owner's live inputs.
// Backpressure: the owner sees wait = !ram_ready, every other requester sees wait = 1 until it is granted.
// Optional: define ARB_PERF_EN to add per-slot grant counters and a global wait-cycle counter.
module mem_arbiter #(
  parameter int NCPU      = 2,
  parameter int BURST_MAX = 8
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [NCPU-1:0]      dREN,
  input  logic [NCPU-1:0]      dWEN,
  input  logic [NCPU*32-1:0]   daddr,
  input  logic [NCPU*32-1:0]   dstore,
  input  logic [NCPU-1:0]      iREN,
  input  logic [NCPU*32-1:0]   iaddr,
  output logic [NCPU-1:0]      dwait,
  output logic [NCPU-1:0]      iwait,
  output logic [NCPU*32-1:0]   dload,
  output logic [NCPU*32-1:0]   iload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore,
  input  logic [31:0]          ramload,
  input  logic                 ram_ready
`ifdef ARB_PERF_EN
  ,
  output logic [2*NCPU*32-1:0] perf_grants,
  output logic [31:0]          perf_wait_cycles
`endif
);

  localparam int NSLOT = 2 * NCPU;
  localparam int SW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int PW    = (NCPU > 1) ? $clog2(NCPU) : 1;
  localparam int CW    = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   owner, owner_nxt;
  logic [PW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [CW-1:0]   word_cnt, word_cnt_nxt;

  logic [NCPU-1:0] d_act;
  logic            win_vld;
  logic [SW-1:0]   win_slot;
  logic            owner_req;
  logic            word_done;
  int              oc;

  assign d_act = dREN | dWEN;

  // Round-robin winner search starting at rr_ptr; dcache beats icache within a CPU.
  always_comb begin
    win_vld  = 1'b0;
    win_slot = '0;
    for (int i = 0; i < NCPU; i++) begin
      if (!win_vld) begin
        if (d_act[(int'(rr_ptr) + i) % NCPU]) begin
          win_vld  = 1'b1;
          win_slot = SW'(2 * ((int'(rr_ptr) + i) % NCPU));
        end else if (iREN[(int'(rr_ptr) + i) % NCPU]) begin
          win_vld  = 1'b1;
          win_slot = SW'(2 * ((int'(rr_ptr) + i) % NCPU) + 1);
        end
      end
    end
  end

  // Owner datapath, wait generation and FSM next state.
  always_comb begin
    dwait        = '1;
    iwait        = '1;
    dload        = '0;
    iload        = '0;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    owner_req    = 1'b0;
    word_done    = 1'b0;
    oc           = int'(owner) / 2;
    state_nxt    = state;
    owner_nxt    = owner;
    rr_ptr_nxt   = rr_ptr;
    word_cnt_nxt = word_cnt;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = BUSY;
          owner_nxt = win_slot;
        end
      end
      BUSY: begin
        // A dropped request suppresses the strobe even if ram_ready rises that cycle.
        if (owner[0]) begin
          owner_req = iREN[oc];
          if (owner_req) begin
            ramREN            = 1'b1;
            ramaddr           = iaddr[oc*32 +: 32];
            iwait[oc]         = !ram_ready;
            iload[oc*32 +: 32] = ramload;
          end
        end else begin
          owner_req = d_act[oc];
          if (owner_req) begin
            ramWEN    = dWEN[oc];
            ramREN    = !dWEN[oc];
            ramaddr   = daddr[oc*32 +: 32];
            ramstore  = dstore[oc*32 +: 32];
            dwait[oc] = !ram_ready;
            if (!dWEN[oc]) dload[oc*32 +: 32] = ramload;
          end
        end
        word_done = owner_req && ram_ready;
        if (!owner_req || (word_done && word_cnt == CW'(BURST_MAX - 1))) begin
          state_nxt    = IDLE;
          rr_ptr_nxt   = PW'((oc + 1) % NCPU);
          word_cnt_nxt = '0;
        end else if (word_done) begin
          word_cnt_nxt = word_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM and arbitration state registers; reset aborts any transfer at once.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      word_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_ptr_nxt;
      word_cnt <= word_cnt_nxt;
    end
  end

`ifdef ARB_PERF_EN
  logic [NSLOT-1:0] slot_act;
  logic [NSLOT-1:0] slot_served;

  // Slot activity and the slot currently being served, for the wait counter.
  always_comb begin
    slot_act    = '0;
    slot_served = '0;
    for (int k = 0; k < NCPU; k++) begin
      slot_act[2*k]   = d_act[k];
      slot_act[2*k+1] = iREN[k];
    end
    if (state == BUSY) slot_served[owner] = 1'b1;
  end

  // Saturating grant and wait counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_grants      <= '0;
      perf_wait_cycles <= '0;
    end else begin
      if (state == IDLE && win_vld && perf_grants[int'(win_slot)*32 +: 32] != 32'hFFFF_FFFF)
        perf_grants[int'(win_slot)*32 +: 32] <= perf_grants[int'(win_slot)*32 +: 32] + 32'd1;
      if (|(slot_act & ~slot_served) && perf_wait_cycles != 32'hFFFF_FFFF)
        perf_wait_cycles <= perf_wait_cycles + 32'd1;
    end
  end
`endif

endmodule
